// File: rtl/target_box_detect.sv
// Per-frame bounding boxes of set motion-mask pixels, split into a left and a right target at SPLIT_X.
// Optional build macro BOX_RUN_FILTER_EN: only pixels inside horizontal runs of at least RUN_MIN are counted.
module target_box_detect #(
    parameter logic [10:0] IMG_HDISP  = 11'd1280,
    parameter logic [9:0]  IMG_VDISP  = 10'd720,
    parameter logic [10:0] SPLIT_X    = 11'd640,
    parameter logic [20:0] MIN_PIXELS = 21'd64
`ifdef BOX_RUN_FILTER_EN
    ,
    parameter logic [3:0]  RUN_MIN    = 4'd4
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic        per_img_bit,
    output logic [42:0] target_pos_out1,
    output logic [42:0] target_pos_out2,
    output logic        target_valid
);

    localparam logic [10:0] XMIN_INIT = 11'h7FF;
    localparam logic [9:0]  YMIN_INIT = 10'h3FF;
    localparam logic [20:0] CNT_MAX   = 21'h1FFFFF;

    function automatic logic [20:0] sat_add(input logic [20:0] a, input logic [20:0] b);
        logic [21:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[21] ? CNT_MAX : s[20:0];
    endfunction

    function automatic logic [42:0] pack_box(input logic [20:0] cnt,
                                             input logic [9:0]  ymax,
                                             input logic [10:0] xmax,
                                             input logic [9:0]  ymin,
                                             input logic [10:0] xmin);
        if (cnt >= MIN_PIXELS)
            return {1'b1, ymax, xmax, ymin, xmin};
        return 43'd0;
    endfunction

    logic        vsync_q, vsync_d;
    logic        sync_ok_q, sync_ok_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [10:0] xmin_q [2];
    logic [10:0] xmin_d [2];
    logic [10:0] xmax_q [2];
    logic [10:0] xmax_d [2];
    logic [9:0]  ymin_q [2];
    logic [9:0]  ymin_d [2];
    logic [9:0]  ymax_q [2];
    logic [9:0]  ymax_d [2];
    logic [20:0] cnt_q  [2];
    logic [20:0] cnt_d  [2];
    logic [42:0] pos1_q, pos1_d;
    logic [42:0] pos2_q, pos2_d;
    logic        valid_q, valid_d;

    logic        pix_vld;
    logic        frame_end;
    logic        rgn;
    logic        acc_en;
    logic [10:0] x_lo;
    logic [20:0] cnt_inc;

    // sync_ok stays low after a reset until vsync has been seen low, so a frame
    // interrupted by reset is neither accumulated nor published.
    assign pix_vld   = per_frame_vsync & sync_ok_q & per_frame_href & per_frame_clken;
    assign frame_end = vsync_q & ~per_frame_vsync & sync_ok_q;
    assign rgn       = (x_q >= SPLIT_X);

`ifdef BOX_RUN_FILTER_EN
    logic [3:0] run_q, run_d, run_base;

    always_comb begin
        run_base = (x_q == 11'd0 || x_q == SPLIT_X) ? 4'd0 : run_q;
        run_d    = run_q;
        acc_en   = 1'b0;
        x_lo     = x_q;
        cnt_inc  = 21'd1;
        if (!per_frame_vsync) begin
            run_d = 4'd0;
        end else if (pix_vld) begin
            if (!per_img_bit) begin
                run_d = 4'd0;
            end else if (run_base >= RUN_MIN) begin
                run_d  = RUN_MIN;
                acc_en = 1'b1;
            end else begin
                run_d = run_base + 4'd1;
                // The run just qualified: credit it retroactively from its first pixel.
                if (run_d == RUN_MIN) begin
                    acc_en  = 1'b1;
                    x_lo    = x_q - {7'd0, RUN_MIN - 4'd1};
                    cnt_inc = {17'd0, RUN_MIN};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) run_q <= 4'd0;
        else     run_q <= run_d;
    end
`else
    always_comb begin
        acc_en  = pix_vld & per_img_bit;
        x_lo    = x_q;
        cnt_inc = 21'd1;
    end
`endif

    always_comb begin
        vsync_d   = per_frame_vsync;
        sync_ok_d = sync_ok_q | ~per_frame_vsync;
        x_d       = x_q;
        y_d       = y_q;
        xmin_d    = xmin_q;
        xmax_d    = xmax_q;
        ymin_d    = ymin_q;
        ymax_d    = ymax_q;
        cnt_d     = cnt_q;
        pos1_d    = pos1_q;
        pos2_d    = pos2_q;
        valid_d   = 1'b0;

        if (!per_frame_vsync) begin
            x_d = 11'd0;
            y_d = 10'd0;
        end else if (pix_vld) begin
            if (x_q == IMG_HDISP - 11'd1) begin
                x_d = 11'd0;
                if (y_q != IMG_VDISP - 10'd1)
                    y_d = y_q + 10'd1;
            end else begin
                x_d = x_q + 11'd1;
            end
        end

        if (frame_end) begin
            pos1_d  = pack_box(cnt_q[0], ymax_q[0], xmax_q[0], ymin_q[0], xmin_q[0]);
            pos2_d  = pack_box(cnt_q[1], ymax_q[1], xmax_q[1], ymin_q[1], xmin_q[1]);
            valid_d = 1'b1;
            xmin_d  = '{XMIN_INIT, XMIN_INIT};
            xmax_d  = '{11'd0, 11'd0};
            ymin_d  = '{YMIN_INIT, YMIN_INIT};
            ymax_d  = '{10'd0, 10'd0};
            cnt_d   = '{21'd0, 21'd0};
        end else if (acc_en) begin
            if (x_lo < xmin_q[rgn]) xmin_d[rgn] = x_lo;
            if (x_q > xmax_q[rgn])  xmax_d[rgn] = x_q;
            if (y_q < ymin_q[rgn])  ymin_d[rgn] = y_q;
            if (y_q > ymax_q[rgn])  ymax_d[rgn] = y_q;
            cnt_d[rgn] = sat_add(cnt_q[rgn], cnt_inc);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q   <= 1'b0;
            sync_ok_q <= 1'b0;
            x_q       <= 11'd0;
            y_q       <= 10'd0;
            xmin_q    <= '{XMIN_INIT, XMIN_INIT};
            xmax_q    <= '{11'd0, 11'd0};
            ymin_q    <= '{YMIN_INIT, YMIN_INIT};
            ymax_q    <= '{10'd0, 10'd0};
            cnt_q     <= '{21'd0, 21'd0};
            pos1_q    <= 43'd0;
            pos2_q    <= 43'd0;
            valid_q   <= 1'b0;
        end else begin
            vsync_q   <= vsync_d;
            sync_ok_q <= sync_ok_d;
            x_q       <= x_d;
            y_q       <= y_d;
            xmin_q    <= xmin_d;
            xmax_q    <= xmax_d;
            ymin_q    <= ymin_d;
            ymax_q    <= ymax_d;
            cnt_q     <= cnt_d;
            pos1_q    <= pos1_d;
            pos2_q    <= pos2_d;
            valid_q   <= valid_d;
        end
    end

    assign target_pos_out1 = pos1_q;
    assign target_pos_out2 = pos2_q;
    assign target_valid    = valid_q;

endmodule
